// File: rtl/axis_read_address_pkg.sv
// axis_read_address_pkg: AXI constants and a log2 helper shared by the axis read path
`ifndef AXIS_READ_ADDRESS_PKG_SV
`define AXIS_READ_ADDRESS_PKG_SV
package axis_read_address_pkg;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam int AXI_4K_BYTES = 4096;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage
`endif

// File: rtl/axis_read_address.sv
// axis_read_address: splits one streaming read transfer into 4 KiB-safe AXI4 INCR read-address bursts
module axis_read_address
  import axis_read_address_pkg::*;
#(
  parameter int CONFIG_DWIDTH  = 32,
  parameter int CONFIG_AWIDTH  = 32,
  parameter int WIDTH_RATIO    = 16,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_LEN_WIDTH  = 8,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int BURST_MAX      = 256
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CONFIG_AWIDTH-1:0]  cfg_address,
  input  logic [CONFIG_DWIDTH-1:0]  cfg_length,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  output logic [AXI_ADDR_WIDTH-1:0] axi_araddr,
  output logic [AXI_LEN_WIDTH-1:0]  axi_arlen,
  output logic [2:0]                axi_arsize,
  output logic [1:0]                axi_arburst,
  output logic                      axi_arvalid,
  input  logic                      axi_arready
);
  localparam int BYTES = AXI_DATA_WIDTH / 8;
  localparam int BSHIFT = clog2(BYTES);
  localparam int RSHIFT = clog2(WIDTH_RATIO);
  localparam int BW = CONFIG_DWIDTH + 1;
  localparam int I_IDLE = 0, I_CONFIG = 1, I_SETUP = 2, I_ACTIVE = 3, I_DONE = 4;
  logic [4:0] state, state_next;
  logic [AXI_ADDR_WIDTH-1:0] addr;
  logic [CONFIG_DWIDTH-1:0] len;
  logic [BW-1:0] beats, blen, beats_cfg, blen_c, beats_left, cap;
  logic [12:0] to4k;
  logic cfg_fire, ar_fire;
  assign axi_arsize = 3'(BSHIFT);
  assign axi_arburst = AXI_BURST_INCR;
  always_ff @(posedge clk) begin
    if (rst) state <= 5'b1 << I_IDLE;
    else state <= state_next;
  end
  always_comb begin
    state_next = state;
    if (cfg_fire) state_next = 5'b1 << I_CONFIG;
    if (state[I_CONFIG]) state_next = 5'b1 << (beats_cfg == '0 ? I_DONE : I_SETUP);
    if (state[I_SETUP]) state_next = 5'b1 << I_ACTIVE;
    if (ar_fire) state_next = 5'b1 << (beats_left == '0 ? I_DONE : I_SETUP);
    if (state[I_DONE]) state_next = 5'b1 << I_IDLE;
  end
  always_comb begin
    cfg_fire = state[I_IDLE] && cfg_valid && cfg_ready;
    ar_fire = state[I_ACTIVE] && axi_arready;
  end
  // extra top bit in beats_cfg keeps the round-up from wrapping at max length
  always_comb begin
    beats_cfg = ({1'b0, len} + BW'(WIDTH_RATIO - 1)) >> RSHIFT;
    to4k = (13'(AXI_4K_BYTES) - {1'b0, addr[11:0]}) >> BSHIFT;
    cap = beats < BW'(BURST_MAX) ? beats : BW'(BURST_MAX);
    blen_c = cap < BW'(to4k) ? cap : BW'(to4k);
    beats_left = beats - blen;
  end
  // cfg_ready rises one cycle after returning to IDLE, so a finished transfer settles first
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_ready <= 1'b1;
      addr <= '0;
      len <= '0;
      beats <= '0;
      blen <= '0;
      axi_araddr <= '0;
      axi_arlen <= '0;
      axi_arvalid <= 1'b0;
    end else begin
      cfg_ready <= state[I_IDLE] && state_next[I_IDLE];
      if (cfg_fire) begin
        addr <= AXI_ADDR_WIDTH'(cfg_address) & ~AXI_ADDR_WIDTH'(BYTES - 1);
        len <= cfg_length;
      end
      if (state[I_CONFIG]) beats <= beats_cfg;
      if (state[I_SETUP]) begin
        blen <= blen_c;
        axi_araddr <= addr;
        axi_arlen <= AXI_LEN_WIDTH'(blen_c - BW'(1));
        axi_arvalid <= 1'b1;
      end
      if (ar_fire) begin
        axi_arvalid <= 1'b0;
        addr <= addr + AXI_ADDR_WIDTH'(blen << BSHIFT);
        beats <= beats_left;
      end
    end
  end
endmodule

// File: tb/tb_axis_read_address.sv
// tb_axis_read_address: table-driven transfers with a burst scoreboard, plus backpressure and reset sequences
module tb_axis_read_address;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] cfg_address = '0;
  logic [31:0] cfg_length = '0;
  logic cfg_valid = 1'b0;
  logic cfg_ready;
  logic [31:0] axi_araddr;
  logic [7:0] axi_arlen;
  logic [2:0] axi_arsize;
  logic [1:0] axi_arburst;
  logic axi_arvalid;
  logic axi_arready = 1'b0;
  always #5 clk = ~clk;
  axis_read_address #(
    .CONFIG_DWIDTH(32), .CONFIG_AWIDTH(32), .WIDTH_RATIO(2), .AXI_ADDR_WIDTH(32),
    .AXI_LEN_WIDTH(8), .AXI_DATA_WIDTH(64), .BURST_MAX(256)
  ) dut (
    .clk(clk), .rst(rst), .cfg_address(cfg_address), .cfg_length(cfg_length),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .axi_araddr(axi_araddr),
    .axi_arlen(axi_arlen), .axi_arsize(axi_arsize), .axi_arburst(axi_arburst),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready)
  );
  typedef struct {
    logic [31:0] addr;
    logic [31:0] len;
    int n;
    logic [31:0] a0;
    int l0;
    logic [31:0] a1;
    int l1;
  } vec_t;
  typedef struct {
    logic [31:0] addr;
    logic [7:0] len;
  } ar_t;
  ar_t sb[$];
  vec_t vecs[10];
  int compared = 0;
  int mismatched = 0;
  task automatic check(input string name, input longint act, input longint exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic run_vec(input vec_t v, input bit stall);
    int first_v, first_hs, rise2, last_hs, ready_at, nb;
    logic prev_v, prev_hs;
    logic [31:0] prev_a;
    logic [7:0] prev_l;
    ar_t e;
    if (v.n > 0) sb.push_back('{v.a0, 8'(v.l0)});
    if (v.n > 1) sb.push_back('{v.a1, 8'(v.l1)});
    cfg_address = v.addr;
    cfg_length = v.len;
    cfg_valid = 1'b1;
    @(negedge clk);
    check("cfg_ready_idle", cfg_ready, 1);
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    first_v = -1; first_hs = -1; rise2 = -1; last_hs = -1; ready_at = -1; nb = 0;
    prev_v = 1'b0; prev_hs = 1'b0; prev_a = '0; prev_l = '0;
    for (int cyc = 1; cyc < 500 && ready_at < 0; cyc++) begin
      axi_arready = stall ? ($urandom_range(0, 2) == 0) : 1'b1;
      @(negedge clk);
      if (prev_v && !prev_hs) begin
        check("hold_arvalid", axi_arvalid, 1);
        check("hold_araddr", axi_araddr, prev_a);
        check("hold_arlen", axi_arlen, prev_l);
      end
      if (axi_arvalid && !prev_v) begin
        if (first_v < 0) first_v = cyc;
        else if (rise2 < 0) rise2 = cyc;
      end
      if (axi_arvalid && axi_arready) begin
        nb++;
        last_hs = cyc;
        if (first_hs < 0) first_hs = cyc;
        if (sb.size() == 0) check("ar_unexpected", 1, 0);
        else begin
          e = sb.pop_front();
          check("araddr", axi_araddr, e.addr);
          check("arlen", axi_arlen, e.len);
        end
      end
      if (cfg_ready) ready_at = cyc;
      prev_v = axi_arvalid; prev_hs = axi_arvalid && axi_arready;
      prev_a = axi_araddr; prev_l = axi_arlen;
      @(posedge clk);
      #1;
    end
    axi_arready = 1'b0;
    check("ready_timeout", ready_at > 0, 1);
    check("burst_count", nb, v.n);
    if (!stall) begin
      if (v.n == 0) begin
        check("zero_len_no_arvalid", first_v, -1);
        check("zero_len_ready_low", ready_at, 4);
      end else begin
        check("cfg_to_arvalid", first_v, 3);
        check("last_hs_to_ready", ready_at - last_hs, 3);
        if (v.n > 1) check("hs_to_next_arvalid", rise2 - first_hs, 2);
      end
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check("ar_missing", 0, 1);
    end
  endtask
  initial begin
    int waited;
    vecs[0] = '{32'h0000_1000, 32, 1, 32'h0000_1000, 15, 32'h0, 0};
    vecs[1] = '{32'h0000_0000, 1000, 2, 32'h0000_0000, 255, 32'h0000_0800, 243};
    vecs[2] = '{32'h0000_0FC0, 64, 2, 32'h0000_0FC0, 7, 32'h0000_1000, 23};
    vecs[3] = '{32'h0000_2003, 5, 1, 32'h0000_2000, 2, 32'h0, 0};
    vecs[4] = '{32'h0000_4000, 0, 0, 32'h0, 0, 32'h0, 0};
    vecs[5] = '{32'h0000_0FF8, 4, 2, 32'h0000_0FF8, 0, 32'h0000_1000, 0};
    vecs[6] = '{32'h0000_1F00, 513, 2, 32'h0000_1F00, 31, 32'h0000_2000, 224};
    vecs[7] = '{32'h0000_3000, 512, 1, 32'h0000_3000, 255, 32'h0, 0};
    vecs[8] = '{32'hFFFF_FFF8, 4, 2, 32'hFFFF_FFF8, 0, 32'h0000_0000, 0};
    vecs[9] = '{32'h0000_5000, 1, 1, 32'h0000_5000, 0, 32'h0, 0};
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_cfg_ready", cfg_ready, 1);
    check("rst_arvalid", axi_arvalid, 0);
    check("rst_araddr", axi_araddr, 0);
    check("rst_arlen", axi_arlen, 0);
    check("arsize", axi_arsize, 3);
    check("arburst", axi_arburst, 1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) run_vec(vecs[i], 1'b0);
    for (int i = 0; i < 10; i++) run_vec(vecs[i], 1'b1);
    cfg_address = 32'h0;
    cfg_length = 1000;
    cfg_valid = 1'b1;
    axi_arready = 1'b0;
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    waited = 0;
    while (!axi_arvalid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("bp_arvalid_seen", axi_arvalid, 1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("bp_arvalid", axi_arvalid, 1);
      check("bp_araddr", axi_araddr, 32'h0);
      check("bp_arlen", axi_arlen, 255);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_arvalid", axi_arvalid, 0);
    check("midrst_cfg_ready", cfg_ready, 1);
    @(posedge clk);
    #1;
    run_vec(vecs[2], 1'b0);
    run_vec(vecs[6], 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/axis_read_address.md
Name: axis_read_address

Overview:
- Issues AXI4 read-address (AR) bursts for one streaming read transfer.
- Sits directly upstream of the AXI read-data stage: both stages are configured with the same transfer length, and the read data returned for these bursts feeds that data stage.
- Splits a configured transfer (start byte address, length in stream words) into INCR bursts of at most BURST_MAX beats.
- No burst crosses a 4 KiB boundary.

Parameters:
- CONFIG_DWIDTH, 32, width of cfg_length and of internal beat counters.
- CONFIG_AWIDTH, 32, width of cfg_address.
- WIDTH_RATIO, 16, stream words per AXI beat; power of two, >=1.
- AXI_ADDR_WIDTH, 32, width of axi_araddr.
- AXI_LEN_WIDTH, 8, width of axi_arlen.
- AXI_DATA_WIDTH, 32, AXI data bus width in bits; power of two, >=8.
- BURST_MAX, 256, max beats per burst; must be <= 2^AXI_LEN_WIDTH and <= 4096/(AXI_DATA_WIDTH/8).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_address  in  CONFIG_AWIDTH  start byte address; low log2(AXI_DATA_WIDTH/8) bits are forced to 0.
- cfg_length  in  CONFIG_DWIDTH  transfer length in stream words.
- cfg_valid  in  1  config offer.
- cfg_ready  out  1  high only in IDLE.
- axi_araddr  out  AXI_ADDR_WIDTH  burst start address.
- axi_arlen  out  AXI_LEN_WIDTH  beats minus one.
- axi_arsize  out  3  constant log2(AXI_DATA_WIDTH/8).
- axi_arburst  out  2  constant 2'b01 (INCR).
- axi_arvalid  out  1  AR request valid.
- axi_arready  in  1  AR accept.

Behaviour:
- Reset: one-hot state = IDLE; axi_arvalid=0; axi_araddr=0; axi_arlen=0; cfg_ready=1 from the first cycle after rst deasserts.
- A reset asserted mid-transfer aborts it: arvalid is 0 on the next cycle, counters are cleared, and the block is in IDLE.
- States (one-hot): IDLE, CONFIG, SETUP, ACTIVE, DONE.
- IDLE: on cfg_valid (cfg_ready=1)
  - latch addr = cfg_address with low bits cleared;
  - latch len = cfg_length;
  - go to CONFIG.
- CONFIG: beats = (len + WIDTH_RATIO-1) >> log2(WIDTH_RATIO), computed with one extra bit so there is no overflow.
  - beats==0 -> DONE.
  - else -> SETUP.
- SETUP: blen = min(beats, BURST_MAX, to4k).
  - to4k = (4096 - addr[11:0]) >> log2(AXI_DATA_WIDTH/8).
  - Register axi_araddr=addr, axi_arlen=blen-1, axi_arvalid=1.
  - Go to ACTIVE.
- ACTIVE: hold arvalid, araddr and arlen stable until axi_arready.
  - On the handshake cycle:
    - arvalid=0 next cycle;
    - addr += blen*(AXI_DATA_WIDTH/8), modulo 2^AXI_ADDR_WIDTH;
    - beats -= blen.
  - Next state: SETUP if remaining beats > 0, else DONE.
- DONE: one cycle, then IDLE.
- cfg_valid outside IDLE is ignored.
- Latency:
  - cfg handshake at cycle N -> first arvalid at N+3.
  - AR handshake at M -> next arvalid at M+2.
  - Last AR handshake at M -> cfg_ready at M+3.
- A trailing partial beat (len not a multiple of WIDTH_RATIO) is fetched whole; discarding the surplus words is the data stage's job.
- axi_arready high while arvalid=0 has no effect.

Decomposition:
- Shared header, guarded like other axis headers, holding:
  - AXI_BURST_INCR = 2'b01;
  - AXI_4K_BYTES = 4096;
  - a clog2 function used for the beat-byte shift and the WIDTH_RATIO shift.
- State indices stay local to the module.
- No sub-module: the 3-way min and the address/beat updates are inline registered logic.

Test Plan (AXI_DATA_WIDTH=64, WIDTH_RATIO=2, BURST_MAX=256):
- Single burst: addr 0x1000, length 32 -> one AR, araddr 0x1000, arlen 15; cfg_ready returns 3 cycles after the handshake.
- Max-length split: addr 0x0, length 1000 (500 beats) -> AR 0x0000/arlen 255, then AR 0x0800/arlen 243.
- 4 KiB crossing: addr 0x0FC0, length 64 (32 beats) -> AR 0x0FC0/arlen 7, then AR 0x1000/arlen 23.
- Odd length plus unaligned address: addr 0x2003, length 5 -> one AR, araddr 0x2000, arlen 2.
- Zero length: length 0 -> no arvalid; cfg_ready low for exactly 3 cycles (CONFIG, DONE, then IDLE).
- Backpressure and reset:
  - arready low 10 cycles -> arvalid, araddr and arlen stable throughout.
  - rst pulsed while ACTIVE -> arvalid=0 and cfg_ready=1 the cycle after rst deasserts.
  - A new transfer then issues correct bursts.
